// File: rtl/mem_port_arbiter.sv
// Single-port RAM arbiter between instruction fetch and the data memory stage.
// Data wins contested arbitration unless fetch has already lost STARVE_LIMIT times in a row.
module mem_port_arbiter #(
    parameter int LATENCY      = 1,
    parameter int STARVE_LIMIT = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic [31:0] if_rdata,
    output logic        if_ack,
    input  logic        dm_req,
    input  logic        dm_we,
    input  logic [31:0] dm_addr,
    input  logic [31:0] dm_wdata,
    output logic [31:0] dm_rdata,
    output logic        dm_ack,
    output logic [31:0] ram_address,
    output logic [31:0] ram_data_in,
    output logic        ram_write_enable,
    input  logic [31:0] ram_data_out,
    output logic        busy,
    output logic        grant_dm
);

    localparam logic [0:0] IDLE      = 1'b0;
    localparam logic [0:0] ACCESS    = 1'b1;
    localparam logic [3:0] LAT_LAST  = 4'(LATENCY);
    localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

    logic [0:0]  state;
    logic [3:0]  latCnt;
    logic [3:0]  starveCnt;
    logic [31:0] addrReg;
    logic [31:0] wdataReg;
    logic        weReg;
    logic        ownerDm;
    logic        ifEligible;
    logic        dmEligible;
    logic        pickFetch;

    // A port whose ack is high this cycle is skipped so a held request is not served twice
    always_comb begin
        ifEligible = if_req && !if_ack;
        dmEligible = dm_req && !dm_ack;
        pickFetch  = ifEligible && (!dmEligible || (starveCnt == STARVE_MAX));
    end

    assign ram_address      = addrReg;
    assign ram_data_in      = wdataReg;
    assign ram_write_enable = (state == ACCESS) && weReg && (latCnt == 4'd1);
    assign busy             = (state == ACCESS);
    assign grant_dm         = ownerDm;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            latCnt    <= 4'd0;
            starveCnt <= 4'd0;
            addrReg   <= 32'd0;
            wdataReg  <= 32'd0;
            weReg     <= 1'b0;
            ownerDm   <= 1'b0;
            if_rdata  <= 32'd0;
            dm_rdata  <= 32'd0;
            if_ack    <= 1'b0;
            dm_ack    <= 1'b0;
        end else begin
            if_ack <= 1'b0;
            dm_ack <= 1'b0;
            if (state == IDLE) begin
                if (ifEligible || dmEligible) begin
                    state  <= ACCESS;
                    latCnt <= 4'd1;
                    if (pickFetch) begin
                        addrReg   <= if_addr;
                        weReg     <= 1'b0;
                        ownerDm   <= 1'b0;
                        starveCnt <= 4'd0;
                    end else begin
                        addrReg  <= dm_addr;
                        wdataReg <= dm_wdata;
                        weReg    <= dm_we;
                        ownerDm  <= 1'b1;
                        // A contested data win implies starveCnt is below the limit, so this saturates
                        if (ifEligible) begin
                            starveCnt <= starveCnt + 4'd1;
                        end
                    end
                end
            end else begin
                if (latCnt == LAT_LAST) begin
                    state  <= IDLE;
                    latCnt <= 4'd0;
                    if (ownerDm) begin
                        dm_ack <= 1'b1;
                        if (!weReg) begin
                            dm_rdata <= ram_data_out;
                        end
                    end else begin
                        if_ack   <= 1'b1;
                        if_rdata <= ram_data_out;
                    end
                end else begin
                    latCnt <= latCnt + 4'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: a transaction-level model predicts each grant,
// its completion edge and its read data; a negedge monitor compares whatever the DUT presents.
module tb_mem_port_arbiter;

    localparam int LATENCY      = 4;
    localparam int STARVE_LIMIT = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_ack;
    logic        dm_req;
    logic        dm_we;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic [31:0] dm_rdata;
    logic        dm_ack;
    logic [31:0] ram_address;
    logic [31:0] ram_data_in;
    logic        ram_write_enable;
    logic [31:0] ram_data_out;
    logic        busy;
    logic        grant_dm;

    mem_port_arbiter #(.LATENCY(LATENCY), .STARVE_LIMIT(STARVE_LIMIT)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_rdata(dm_rdata), .dm_ack(dm_ack),
        .ram_address(ram_address), .ram_data_in(ram_data_in),
        .ram_write_enable(ram_write_enable), .ram_data_out(ram_data_out),
        .busy(busy), .grant_dm(grant_dm)
    );

    always #5 clk = ~clk;

    logic [31:0] ramArray [0:255];
    logic [31:0] modelMem [0:255];

    assign ram_data_out = ramArray[ram_address[7:0]];

    always @(posedge clk) begin
        if (ram_write_enable) ramArray[ram_address[7:0]] <= ram_data_in;
    end

    typedef struct {
        logic [31:0] data;
        int          ackCycle;
    } expT;

    expT         ifQ[$];
    expT         dmQ[$];
    int          cyc = 0;
    int          total = 0;
    int          bad = 0;
    int          mDone = 0;
    int          mStarve = 0;
    bit          mBusy = 0;
    bit          mOwnerDm = 0;
    bit          mAckIf = 0;
    bit          mAckDm = 0;
    bit          expWe = 0;
    logic [31:0] lastDmData = 32'd0;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s actual=%h expected=%h at edge %0d", name, act, exp, cyc);
        end
    endtask

    // Reference: one access at a time, completing LATENCY edges after its grant
    always @(posedge clk) begin : refModel
        bit  ifElig, dmElig, fetchWins, prevAckIf, prevAckDm;
        expT e;
        cyc++;
        expWe     = 1'b0;
        prevAckIf = mAckIf;
        prevAckDm = mAckDm;
        mAckIf    = 1'b0;
        mAckDm    = 1'b0;
        if (rst) begin
            mBusy = 0; mOwnerDm = 0; mStarve = 0; lastDmData = 32'd0;
            ifQ.delete();
            dmQ.delete();
        end else if (mBusy) begin
            if (cyc == mDone) begin
                mBusy = 0;
                if (mOwnerDm) mAckDm = 1'b1;
                else          mAckIf = 1'b1;
            end
        end else begin
            ifElig = if_req && !prevAckIf;
            dmElig = dm_req && !prevAckDm;
            if (ifElig || dmElig) begin
                fetchWins  = ifElig && (!dmElig || mStarve == STARVE_LIMIT);
                mBusy      = 1;
                mDone      = cyc + LATENCY;
                mOwnerDm   = !fetchWins;
                e.ackCycle = mDone;
                if (fetchWins) begin
                    mStarve = 0;
                    e.data  = modelMem[if_addr[7:0]];
                    ifQ.push_back(e);
                end else begin
                    if (ifElig) mStarve++;
                    if (dm_we) begin
                        modelMem[dm_addr[7:0]] = dm_wdata;
                        e.data = lastDmData;
                        expWe  = 1'b1;
                    end else begin
                        e.data     = modelMem[dm_addr[7:0]];
                        lastDmData = e.data;
                    end
                    dmQ.push_back(e);
                end
            end
        end
    end

    always @(negedge clk) begin : monitor
        expT e;
        checkOutput("if_ack", {31'd0, if_ack}, {31'd0, mAckIf});
        checkOutput("dm_ack", {31'd0, dm_ack}, {31'd0, mAckDm});
        checkOutput("busy", {31'd0, busy}, {31'd0, mBusy});
        checkOutput("grant_dm", {31'd0, grant_dm}, {31'd0, mOwnerDm});
        checkOutput("ram_write_enable", {31'd0, ram_write_enable}, {31'd0, expWe});
        if (if_ack) begin
            if (ifQ.size() == 0) checkOutput("if_ack_unexpected", {31'd0, if_ack}, 32'd0);
            else begin
                e = ifQ.pop_front();
                checkOutput("if_rdata", if_rdata, e.data);
                checkOutput("if_ack_edge", cyc, e.ackCycle);
            end
        end
        if (dm_ack) begin
            if (dmQ.size() == 0) checkOutput("dm_ack_unexpected", {31'd0, dm_ack}, 32'd0);
            else begin
                e = dmQ.pop_front();
                checkOutput("dm_rdata", dm_rdata, e.data);
                checkOutput("dm_ack_edge", cyc, e.ackCycle);
            end
        end
    end

    task automatic applyStimulus(input int cycles);
        for (int n = 0; n < cycles; n++) begin
            @(negedge clk);
            if (if_req) begin
                if (if_ack ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 24) == 0)) if_req = 1'b0;
            end else if ($urandom_range(0, 2) == 0) begin
                if_req  = 1'b1;
                if_addr = $urandom;
            end
            if (dm_req) begin
                if (dm_ack ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 24) == 0)) dm_req = 1'b0;
            end else if ($urandom_range(0, 2) == 0) begin
                dm_req   = 1'b1;
                dm_we    = 1'($urandom_range(0, 1));
                dm_addr  = $urandom;
                dm_wdata = $urandom;
            end
        end
    endtask

    task automatic waitQuiet();
        int n = 0;
        if_req = 1'b0;
        dm_req = 1'b0;
        @(negedge clk);
        while ((busy || if_ack || dm_ack) && n < 40) begin
            @(negedge clk);
            n++;
        end
        checkOutput("quiet_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
    endtask

    task automatic waitAck(input string name);
        int n = 0;
        while (!(if_ack || dm_ack) && n < 30) begin
            @(negedge clk);
            n++;
        end
        checkOutput(name, {31'd0, (if_ack || dm_ack)}, 32'd1);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            ramArray[i] = $urandom;
            modelMem[i] = ramArray[i];
        end
        ramArray[8'h10] = 32'hDEADBEEF;
        modelMem[8'h10] = 32'hDEADBEEF;
        rst = 1'b1; if_req = 1'b0; if_addr = 32'd0;
        dm_req = 1'b0; dm_we = 1'b0; dm_addr = 32'd0; dm_wdata = 32'd0;
        repeat (3) @(negedge clk);
        checkOutput("reset_if_rdata", if_rdata, 32'd0);
        checkOutput("reset_dm_rdata", dm_rdata, 32'd0);
        checkOutput("reset_ram_address", ram_address, 32'd0);
        checkOutput("reset_ram_data_in", ram_data_in, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Fetch withdraws after each contested loss, so only starvation lets it win round 3
        for (int k = 0; k < 5; k++) begin
            if_req = 1'b1; if_addr = 32'h10;
            dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h20 + 32'(k);
            @(negedge clk);
            checkOutput("contest_owner", {31'd0, grant_dm}, (k == 3) ? 32'd0 : 32'd1);
            if (grant_dm) if_req = 1'b0;
            else          dm_req = 1'b0;
            waitAck("contest_ack");
            if_req = 1'b0; dm_req = 1'b0;
            @(negedge clk);
            @(negedge clk);
        end

        waitQuiet();
        if_req = 1'b1; if_addr = 32'h10;
        @(negedge clk);
        if_req = 1'b0;
        waitAck("fetch_drop_ack");
        checkOutput("fetch_data", if_rdata, 32'hDEADBEEF);
        waitQuiet();

        dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h40; dm_wdata = 32'h12345678;
        waitAck("store_ack");
        dm_req = 1'b0;
        waitQuiet();
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h40;
        waitAck("load_ack");
        checkOutput("load_data", dm_rdata, 32'h12345678);
        waitQuiet();

        applyStimulus(1500);
        waitQuiet();

        // Reset lands in the second cycle of a store
        dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h44; dm_wdata = 32'hA5A5A5A5;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1; dm_req = 1'b0;
        @(negedge clk);
        checkOutput("rst_busy", {31'd0, busy}, 32'd0);
        checkOutput("rst_we", {31'd0, ram_write_enable}, 32'd0);
        checkOutput("rst_dm_rdata", dm_rdata, 32'd0);
        checkOutput("rst_if_rdata", if_rdata, 32'd0);
        checkOutput("rst_ram_address", ram_address, 32'd0);
        rst = 1'b0;
        if_req = 1'b1; if_addr = 32'h10;
        @(negedge clk);
        waitAck("post_reset_ack");
        checkOutput("post_reset_data", if_rdata, 32'hDEADBEEF);

        applyStimulus(800);
        waitQuiet();
        checkOutput("if_queue_drained", 32'(ifQ.size()), 32'd0);
        checkOutput("dm_queue_drained", 32'(dmQ.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
